rnn_feature_frame_loader: RTL

//  Producer end of the RNN feature input. Accepts a stream of FIXED-bit feature words over

---
 rtl/rnn_feature_frame_loader.sv | 118 +++++++++++
 1 files changed

// File: rtl/rnn_feature_frame_loader.sv
// Feature frame loader: assembles N_FEAT streamed words into a frame and holds it for the RNN.
// The fill buffer and the hold register are separate, so the next frame can fill while the RNN works.
module rnn_feature_frame_loader #(
  parameter int FIXED  = 32,
  parameter int N_FEAT = 42,
  parameter int CNT_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [FIXED-1:0]        s_data,
  input  logic                    s_last,
  output logic [N_FEAT*FIXED-1:0] feature,
  output logic                    feature_valid,
  input  logic                    feature_ack,
  output logic                    frame_err
);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FEAT - 1);
  localparam logic [CNT_W-1:0] IDX_ONE  = CNT_W'(1);

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             idx_q, idx_d;
  logic [N_FEAT-1:0][FIXED-1:0] fill_q, fill_d;
  logic [N_FEAT-1:0][FIXED-1:0] hold_q, hold_d;
  logic                         fv_q, fv_d;
  logic                         err_q, err_d;
  logic                         rdy_q, rdy_d;
  logic                         accept_s;

  assign accept_s      = s_valid && rdy_q;
  assign s_ready       = rdy_q;
  assign feature       = hold_q;
  assign feature_valid = fv_q;
  assign frame_err     = err_q;

  // Next-state logic: word capture, frame-end checks and fill->hold transfer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fill_d  = fill_q;
    hold_d  = hold_q;
    err_d   = 1'b0;

    if (feature_ack && fv_q) begin
      fv_d = 1'b0;
    end else begin
      fv_d = fv_q;
    end

    case (state_q)
      ST_FILL: begin
        if (accept_s) begin
          fill_d[idx_q] = s_data;
          if (idx_q == LAST_IDX) begin
            idx_d = {CNT_W{1'b0}};
            if (s_last) begin
              state_d = ST_XFER;
            end else begin
              err_d = 1'b1;
            end
          end else if (s_last) begin
            idx_d = {CNT_W{1'b0}};
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_XFER: begin
        // An ack in the same cycle frees the hold register, so the reload has no bubble.
        if (!fv_q || feature_ack) begin
          hold_d  = fill_q;
          fv_d    = 1'b1;
          state_d = ST_FILL;
        end else begin
          state_d = ST_XFER;
        end
      end
      default: begin
        state_d = ST_FILL;
        idx_d   = {CNT_W{1'b0}};
      end
    endcase

    rdy_d = (state_d == ST_FILL);
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      idx_q   <= {CNT_W{1'b0}};
      fill_q  <= {(N_FEAT*FIXED){1'b0}};
      hold_q  <= {(N_FEAT*FIXED){1'b0}};
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule
